// File: rtl/cmp_arb_pkg.sv
// Shared types and default sizing for the round-robin compare arbiter.
// Used by cmp_core and cmp_arbiter (CMP_ARB_SIGNED_EN selects signed less-than in cmp_core).
package cmp_arb_pkg;

    localparam int CMP_N_REQ = 4;
    localparam int CMP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } cmp_state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational subtract-based magnitude/equality comparator.
// CMP_ARB_SIGNED_EN defined: two's-complement less-than; undefined: unsigned less-than.
module cmp_core
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt
);

    logic [WIDTH:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};
    assign eq   = (diff[WIDTH-1:0] == '0);

`ifdef CMP_ARB_SIGNED_EN
    logic sign;
    logic ovf;

    // Overflow only when operand signs differ and the result sign disagrees with A.
    assign sign = diff[WIDTH-1];
    assign ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sign);
    assign lt   = sign ^ ovf;
`else
    assign lt   = diff[WIDTH];
`endif

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered compare stage between N_REQ requesters.
// Less-than flavour is chosen inside cmp_core by CMP_ARB_SIGNED_EN.
module cmp_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int N_REQ = CMP_N_REQ,
    parameter int WIDTH = CMP_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_eq,
    output logic                   rsp_lt,
    output logic                   busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Requesters hold valid (operands may change) until accepted; req_ready never
    // depends on rsp_ready, and rsp_* stay stable while rsp_valid && !rsp_ready.

    cmp_state_e         state;
    cmp_state_e         state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      scan;
    logic               grant_found;
    logic [N_REQ-1:0]   grant_oh;
    logic               accept;
    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               core_eq;
    logic               core_lt;
    logic               eq_q;
    logic               lt_q;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign a_arr[k] = req_a[k*WIDTH +: WIDTH];
        assign b_arr[k] = req_b[k*WIDTH +: WIDTH];
    end

    // Scan upward from rr_ptr, wrapping modulo N_REQ; first valid index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_oh    = '0;
        scan        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan >= (ID_W+1)'(N_REQ)) begin
                scan = scan - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[scan[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan[ID_W-1:0];
            end
        end
        grant_oh[grant_id] = grant_found;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Ready is masked while reset is held so nothing appears accepted.
                if (grant_found && rst_n) begin
                    accept     = 1'b1;
                    req_ready  = grant_oh;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (a_q),
        .b  (b_q),
        .eq (core_eq),
        .lt (core_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= a_arr[grant_id];
                b_q    <= b_arr[grant_id];
                id_q   <= grant_id;
                rr_ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
            end
            if (state == EXEC) begin
                eq_q <= core_eq;
                lt_q <= core_lt;
            end
        end
    end

    assign rsp_id = id_q;
    assign rsp_eq = eq_q;
    assign rsp_lt = lt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed and randomized bench for cmp_arbiter against a cycle-level reference model.
// Expected less-than follows CMP_ARB_SIGNED_EN when defined.
module tb_cmp_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic           rsp_eq;
    logic           rsp_lt;
    logic           busy;

    cmp_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .ID_W  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: one transaction outstanding at most, result visible two
    // cycles after acceptance, pointer rotates past the last grant.
    int                 m_ptr = 0;
    bit                 m_out = 1'b0;
    int                 m_age = 0;
    int                 m_last_g = -1;
    logic [IDW+1:0]     exp_q[$];

    int obs_grants[$];
    int rsp_ids[$];
    int rsp_cycles[$];

    logic [W-1:0] corners [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_lt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_ARB_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    function automatic int first_from(input logic [N-1:0] v, input int ptr);
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = (ptr + i) % N;
            if (v[idx[IDW-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return W'($urandom());
            1:       return corners[$urandom_range(0, 3)];
            2:       return W'($urandom_range(0, 7));
            default: return W'($urandom());
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    task automatic drive_random_operands();
        logic [W-1:0] a;
        for (int k = 0; k < N; k++) begin
            a = rand_val();
            set_op(k, a, ($urandom_range(0, 3) == 0) ? a : rand_val());
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_out = 1'b0;
        m_age = 0;
        m_last_g = -1;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, req_ready, 0);
        check({tag, ".rsp_valid"}, rsp_valid, 0);
        check({tag, ".rsp_id"},    rsp_id,    0);
        check({tag, ".rsp_eq"},    rsp_eq,    0);
        check({tag, ".rsp_lt"},    rsp_lt,    0);
        check({tag, ".busy"},      busy,      0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: compare against the model just after the inputs settle,
    // advance the model to match the coming rising edge, then wait for negedge.
    task automatic tick(input string tag);
        logic [N-1:0]   er;
        logic [IDW+1:0] e;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        int             g;
        #1;
        g  = m_out ? -1 : first_from(req_valid, m_ptr);
        er = '0;
        if (g >= 0) er[g[IDW-1:0]] = 1'b1;
        check({tag, ".req_ready"}, req_ready, er);
        check({tag, ".busy"},      busy,      m_out);
        check({tag, ".rsp_valid"}, rsp_valid, (m_out && m_age >= 2));
        if (m_out && m_age >= 2 && exp_q.size() > 0) begin
            e = exp_q[0];
            check({tag, ".rsp_id"}, rsp_id, e[IDW+1:2]);
            check({tag, ".rsp_eq"}, rsp_eq, e[1]);
            check({tag, ".rsp_lt"}, rsp_lt, e[0]);
        end
        for (int k = 0; k < N; k++) begin
            if (req_ready[k[IDW-1:0]]) obs_grants.push_back(k);
        end
        if (rsp_valid && rsp_ready) begin
            rsp_ids.push_back(int'(rsp_id));
            rsp_cycles.push_back(cyc);
        end
        m_last_g = g;
        if (g >= 0) begin
            a = W'(req_a >> (g * W));
            b = W'(req_b >> (g * W));
            exp_q.push_back({g[IDW-1:0], (a == b), ref_lt(a, b)});
            m_out = 1'b1;
            m_age = 1;
            m_ptr = (g + 1) % N;
        end else if (m_out) begin
            if (m_age >= 2 && rsp_ready) begin
                void'(exp_q.pop_front());
                m_out = 1'b0;
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [W-1:0] ctab_a  [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0007};
    logic [W-1:0] ctab_b  [4] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0002, 32'h0000_0007};
    logic         ctab_eq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CMP_ARB_SIGNED_EN
    logic         ctab_lt [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
    logic         ctab_lt [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
    int           exp_g   [5] = '{0, 1, 2, 3, 0};

    initial begin
        rsp_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // Single request from requester 2, equal operands.
        set_op(2, 32'h0000_0005, 32'h0000_0005);
        req_valid = 4'b0100;
        #1;
        check("single.ready_at_T", req_ready, 4'b0100);
        tick("single_T");
        req_valid = '0;
        tick("single_T1");
        #1;
        check("single.rsp_valid_T2", rsp_valid, 1);
        check("single.rsp_id",       rsp_id,    2);
        check("single.rsp_eq",       rsp_eq,    1);
        check("single.rsp_lt",       rsp_lt,    0);
        tick("single_T2");
        tick("single_T3");

        // All requesters continuously valid: rotation and 3-cycle spacing.
        do_reset();
        obs_grants.delete();
        rsp_ids.delete();
        rsp_cycles.delete();
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (15) begin
            drive_random_operands();
            tick("fair");
        end
        req_valid = '0;
        repeat (3) tick("fair_drain");
        check("fair.grant_count", obs_grants.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < obs_grants.size()) check($sformatf("fair.grant%0d", i), obs_grants[i], exp_g[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < rsp_ids.size()) check($sformatf("fair.rsp_id%0d", i), rsp_ids[i], exp_g[i]);
            if (i + 1 < rsp_cycles.size())
                check($sformatf("fair.spacing%0d", i), rsp_cycles[i+1] - rsp_cycles[i], 3);
        end

        // Corner operand pairs, including the signed-overflow case.
        for (int i = 0; i < 4; i++) begin
            set_op(i % N, ctab_a[i], ctab_b[i]);
            req_valid = '0;
            req_valid[i % N] = 1'b1;
            tick("corner_T");
            req_valid = '0;
            tick("corner_T1");
            #1;
            check($sformatf("corner%0d.eq", i), rsp_eq, ctab_eq[i]);
            check($sformatf("corner%0d.lt", i), rsp_lt, ctab_lt[i]);
            tick("corner_T2");
        end

        // Backpressure: response held while requester 1 waits.
        set_op(0, 32'h1234_5678, 32'h1234_5678);
        set_op(1, 32'h0000_0003, 32'h0000_0009);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick("bp_accept");
        req_valid = 4'b0010;
        tick("bp_exec");
        repeat (5) begin
            #1;
            check("bp.rsp_valid", rsp_valid, 1);
            check("bp.rsp_id",    rsp_id,    0);
            check("bp.rsp_eq",    rsp_eq,    1);
            check("bp.req_ready", req_ready, 0);
            tick("bp_hold");
        end
        rsp_ready = 1'b1;
        tick("bp_release");
        #1;
        check("bp.grant_req1", req_ready, 4'b0010);
        tick("bp_accept1");
        req_valid = '0;
        tick("bp_exec1");
        tick("bp_resp1");

        // Reset asserted during EXEC discards the result and clears the pointer.
        set_op(2, 32'h0000_0010, 32'h0000_0020);
        req_valid = 4'b0100;
        tick("rst_accept");
        req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick("rst_after");
        req_valid = 4'b1001;
        #1;
        check("rst.grant_req0", req_ready, 4'b0001);
        tick("rst_grant");
        req_valid = '0;
        repeat (3) tick("rst_drain");

        // Randomized traffic with random backpressure.
        do_reset();
        repeat (400) begin
            if (m_last_g >= 0) req_valid[m_last_g[IDW-1:0]] = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k[IDW-1:0]] && $urandom_range(0, 2) == 0) req_valid[k[IDW-1:0]] = 1'b1;
            end
            drive_random_operands();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
